dtw_sequencer: RTL

Main DTW control FSM. It produces the 4-bit `dtw_state` code consumed by the memory write-enable decoder, the template/test fill addresses and the cost-matrix row/column indices. It loads the template sequence (length N) and then the test sequence (length M). It then walks the N×M cost matrix row by row, alternating between the even and odd row-memory states, and pulses `done` at completion.

---
 rtl/dtw_sequencer_if.sv | 61 ++++++
 rtl/dtw_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dtw_sequencer_if.sv
// dtw_sequencer_if
// Bundles the control/handshake signals between the DTW host side and the
// DTW sequencer. clk and rst stay outside the interface as plain ports.
//
// Signals (LEN_WIDTH = width of lengths, addresses and indices):
//   start       host -> seq   begin a run (honoured only in the idle state)
//   temp_len    host -> seq   template length N, sampled on accepted start
//   test_len    host -> seq   test length M, sampled on accepted start
//   data_valid  host -> seq   a sample is present on the external data bus
//   calc_stall  host -> seq   freeze compute (only with DTW_SEQ_STALL_EN)
//   data_ready  seq -> host   high while filling template or test memory
//   dtw_state   seq -> host   4-bit state code for the write-enable decoder
//   fill_addr   seq -> host   template/test memory write address
//   row_idx     seq -> host   current test index i
//   col_idx     seq -> host   current template index j
//   busy        seq -> host   high whenever not idle
//   done        seq -> host   single-cycle completion pulse
//
// Optional feature macro: DTW_SEQ_STALL_EN adds calc_stall.

interface dtw_sequencer_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] temp_len;
  logic [LEN_WIDTH-1:0] test_len;
  logic                 data_valid;
`ifdef DTW_SEQ_STALL_EN
  logic                 calc_stall;
`endif
  logic                 data_ready;
  logic [3:0]           dtw_state;
  logic [LEN_WIDTH-1:0] fill_addr;
  logic [LEN_WIDTH-1:0] row_idx;
  logic [LEN_WIDTH-1:0] col_idx;
  logic                 busy;
  logic                 done;

`ifdef DTW_SEQ_STALL_EN
  modport master (
    output start, temp_len, test_len, data_valid, calc_stall,
    input  data_ready, dtw_state, fill_addr, row_idx, col_idx, busy, done
  );

  modport slave (
    input  start, temp_len, test_len, data_valid, calc_stall,
    output data_ready, dtw_state, fill_addr, row_idx, col_idx, busy, done
  );
`else
  modport master (
    output start, temp_len, test_len, data_valid,
    input  data_ready, dtw_state, fill_addr, row_idx, col_idx, busy, done
  );

  modport slave (
    input  start, temp_len, test_len, data_valid,
    output data_ready, dtw_state, fill_addr, row_idx, col_idx, busy, done
  );
`endif

endinterface

// File: rtl/dtw_sequencer.sv
// dtw_sequencer
// Main DTW control FSM. Loads the template sequence (length N), then the test
// sequence (length M), then walks the N x M cost matrix row by row. Row 0 uses
// states 3/4, odd rows use 5/6 and even rows (>= 2) use 7/8 so the downstream
// decoder can alternate between the two row memories. done pulses in state 9.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   dtw_sequencer_if.slave (start, temp_len, test_len, data_valid,
//         [calc_stall], data_ready, dtw_state, fill_addr, row_idx, col_idx,
//         busy, done)
//
// Optional feature macro: DTW_SEQ_STALL_EN. When defined, calc_stall=1 in the
// compute states (3..8) holds state and indices so the current cell repeats.
// LEN_WIDTH must match the LEN_WIDTH of the connected interface instance.

module dtw_sequencer #(
  parameter int LEN_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  dtw_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_INITIAL         = 4'd0,
    S_TEMP_FILL       = 4'd1,
    S_TEST_FILL       = 4'd2,
    S_FIRST_CELL      = 4'd3,
    S_FIRST_ROW       = 4'd4,
    S_ODD_FIRST_CELL  = 4'd5,
    S_ODD_ROW         = 4'd6,
    S_EVEN_FIRST_CELL = 4'd7,
    S_EVEN_ROW        = 4'd8,
    S_FINAL           = 4'd9
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t               state;
  logic [LEN_WIDTH-1:0] n_len;
  logic [LEN_WIDTH-1:0] m_len;
  logic [LEN_WIDTH-1:0] fill_addr;
  logic [LEN_WIDTH-1:0] row_idx;
  logic [LEN_WIDTH-1:0] col_idx;
  logic                 data_ready;
  logic                 busy;
  logic                 done;

  logic                 calc_go;
  logic                 row_last;
  logic                 col_last;
  logic                 n_multi;
  logic [LEN_WIDTH-1:0] row_inc;
  state_t               eor_state;

  // The flag outputs are a pure function of the state being entered, so they
  // are loaded together with the state register and stay registered.
  function automatic logic [2:0] flags_for(input state_t s);
    logic [2:0] f;
    f[2] = (s == S_TEMP_FILL) || (s == S_TEST_FILL);
    f[1] = (s != S_INITIAL);
    f[0] = (s == S_FINAL);
    return f;
  endfunction

`ifdef DTW_SEQ_STALL_EN
  assign calc_go = !bus.calc_stall;
`else
  assign calc_go = 1'b1;
`endif

  // End-of-row decision shared by every compute state. The next row's
  // parity picks which first-cell state it starts in; row 0 never comes back
  // here as a target because i only increases.
  always_comb begin
    row_last  = (row_idx == m_len - ONE);
    col_last  = (col_idx == n_len - ONE);
    n_multi   = (n_len != ONE);
    row_inc   = row_idx + ONE;
    eor_state = S_FINAL;
    if (!row_last) begin
      eor_state = row_inc[0] ? S_ODD_FIRST_CELL : S_EVEN_FIRST_CELL;
    end
  end

  // Whole sequencer in one registered block. Indices are cleared on an
  // accepted start and otherwise held after a run, so the last cell stays
  // visible while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= S_INITIAL;
      n_len                     <= '0;
      m_len                     <= '0;
      fill_addr                 <= '0;
      row_idx                   <= '0;
      col_idx                   <= '0;
      {data_ready, busy, done}  <= 3'b000;
    end else begin
      case (state)
        S_INITIAL: begin
          if (bus.start && (bus.temp_len != '0) && (bus.test_len != '0)) begin
            n_len                    <= bus.temp_len;
            m_len                    <= bus.test_len;
            fill_addr                <= '0;
            row_idx                  <= '0;
            col_idx                  <= '0;
            state                    <= S_TEMP_FILL;
            {data_ready, busy, done} <= flags_for(S_TEMP_FILL);
          end
        end

        S_TEMP_FILL: begin
          if (bus.data_valid) begin
            if (fill_addr == n_len - ONE) begin
              fill_addr                <= '0;
              state                    <= S_TEST_FILL;
              {data_ready, busy, done} <= flags_for(S_TEST_FILL);
            end else begin
              fill_addr <= fill_addr + ONE;
            end
          end
        end

        S_TEST_FILL: begin
          if (bus.data_valid) begin
            if (fill_addr == m_len - ONE) begin
              fill_addr                <= '0;
              state                    <= S_FIRST_CELL;
              {data_ready, busy, done} <= flags_for(S_FIRST_CELL);
            end else begin
              fill_addr <= fill_addr + ONE;
            end
          end
        end

        // First cell of any row: step into the row interior when the
        // template has more than one sample, otherwise the row is already
        // complete and the end-of-row rule applies immediately.
        S_FIRST_CELL, S_ODD_FIRST_CELL, S_EVEN_FIRST_CELL: begin
          if (calc_go) begin
            if (n_multi) begin
              col_idx <= ONE;
              if (state == S_FIRST_CELL) begin
                state                    <= S_FIRST_ROW;
                {data_ready, busy, done} <= flags_for(S_FIRST_ROW);
              end else if (state == S_ODD_FIRST_CELL) begin
                state                    <= S_ODD_ROW;
                {data_ready, busy, done} <= flags_for(S_ODD_ROW);
              end else begin
                state                    <= S_EVEN_ROW;
                {data_ready, busy, done} <= flags_for(S_EVEN_ROW);
              end
            end else begin
              state                    <= eor_state;
              {data_ready, busy, done} <= flags_for(eor_state);
              if (!row_last) begin
                row_idx <= row_inc;
                col_idx <= '0;
              end
            end
          end
        end

        S_FIRST_ROW, S_ODD_ROW, S_EVEN_ROW: begin
          if (calc_go) begin
            if (col_last) begin
              state                    <= eor_state;
              {data_ready, busy, done} <= flags_for(eor_state);
              if (!row_last) begin
                row_idx <= row_inc;
                col_idx <= '0;
              end
            end else begin
              col_idx <= col_idx + ONE;
            end
          end
        end

        S_FINAL: begin
          state                    <= S_INITIAL;
          {data_ready, busy, done} <= flags_for(S_INITIAL);
        end

        default: begin
          state                    <= S_INITIAL;
          {data_ready, busy, done} <= 3'b000;
        end
      endcase
    end
  end

  assign bus.dtw_state  = state;
  assign bus.fill_addr  = fill_addr;
  assign bus.row_idx    = row_idx;
  assign bus.col_idx    = col_idx;
  assign bus.data_ready = data_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule
